// File: rtl/knn_topk_vote.sv
// rtl/knn_topk_vote.sv - K-nearest list by one-cycle sorted insertion, then K-step majority vote
module knn_topk_vote #(
    parameter int K       = 4,
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 8,
    parameter int AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               in_ready,
    output logic               busy,
    output logic               result_valid,
    output logic [LABEL_W-1:0] result_label,
    output logic [15:0]        num_pts,
    input  logic [AW-1:0]      rd_addr,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_vld
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_t;
    state_t state;

    logic [DIST_W-1:0]  list_dist  [K];
    logic [LABEL_W-1:0] list_label [K];
    logic               list_vld   [K];

    logic [DIST_W-1:0]  nxt_dist   [K];
    logic [LABEL_W-1:0] nxt_label  [K];
    logic               nxt_vld    [K];
    logic               ge         [K];

    logic [CW-1:0]      vi;
    logic [CW-1:0]      best_cnt;
    logic [LABEL_W-1:0] best_label;
    logic [CW-1:0]      cur_cnt;
    logic [LABEL_W-1:0] cur_label;
    logic               cur_vld;

    logic accept;
    assign accept = (state == COLLECT) && in_valid;

    // Sorted + contiguous list makes ge[] a prefix: keep it, insert right after it, shift the rest.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            ge[i]        = list_vld[i] && (list_dist[i] <= in_dist);
            nxt_dist[i]  = list_dist[i];
            nxt_label[i] = list_label[i];
            nxt_vld[i]   = list_vld[i];
        end
        for (int i = 0; i < K; i++) begin
            if (!ge[i]) begin
                if (i == 0 || ge[(i == 0) ? 0 : i - 1]) begin
                    nxt_dist[i]  = in_dist;
                    nxt_label[i] = in_label;
                    nxt_vld[i]   = 1'b1;
                end else begin
                    nxt_dist[i]  = list_dist[(i == 0) ? 0 : i - 1];
                    nxt_label[i] = list_label[(i == 0) ? 0 : i - 1];
                    nxt_vld[i]   = list_vld[(i == 0) ? 0 : i - 1];
                end
            end
        end
    end

    always_comb begin
        cur_label = '0;
        cur_vld   = 1'b0;
        cur_cnt   = '0;
        for (int i = 0; i < K; i++) begin
            if (CW'(i) == vi) begin
                cur_label = list_label[i];
                cur_vld   = list_vld[i];
            end
        end
        for (int j = 0; j < K; j++) begin
            if (list_vld[j] && (list_label[j] == cur_label))
                cur_cnt = cur_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            num_pts      <= '0;
            result_label <= '0;
            vi           <= '0;
            best_cnt     <= '0;
            best_label   <= '0;
            for (int i = 0; i < K; i++) begin
                list_dist[i]  <= '0;
                list_label[i] <= '0;
                list_vld[i]   <= 1'b0;
            end
        end else if (start) begin
            state   <= COLLECT;
            num_pts <= '0;
            for (int i = 0; i < K; i++) begin
                list_dist[i]  <= '0;
                list_label[i] <= '0;
                list_vld[i]   <= 1'b0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < K; i++) begin
                            list_dist[i]  <= nxt_dist[i];
                            list_label[i] <= nxt_label[i];
                            list_vld[i]   <= nxt_vld[i];
                        end
                        if (num_pts != 16'hFFFF)
                            num_pts <= num_pts + 16'd1;
                        if (in_last) begin
                            state      <= VOTE;
                            vi         <= '0;
                            best_cnt   <= '0;
                            best_label <= '0;
                        end
                    end
                end
                VOTE: begin
                    // K scoring steps, then one cycle to publish the winner.
                    if (vi < CW'(K)) begin
                        if (cur_vld && (cur_cnt > best_cnt)) begin
                            best_cnt   <= cur_cnt;
                            best_label <= cur_label;
                        end
                        vi <= vi + CW'(1);
                    end else begin
                        result_label <= best_label;
                        state        <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dist  <= '0;
            rd_label <= '0;
            rd_vld   <= 1'b0;
        end else begin
            rd_dist  <= '0;
            rd_label <= '0;
            rd_vld   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                if (rd_addr == AW'(i)) begin
                    rd_dist  <= list_dist[i];
                    rd_label <= list_label[i];
                    rd_vld   <= list_vld[i];
                end
            end
        end
    end

    assign in_ready     = (state == COLLECT);
    assign busy         = (state == COLLECT) || (state == VOTE);
    assign result_valid = (state == DONE);
endmodule
